rob_core: RTL and testbench

- Reorder buffer sitting between dispatch/rename and the register file.
- Allocates a ROB id per dispatched instruction and captures results from the two CDBs (ALU and load).
- Answers the register file's two operand-readiness queries.
- Retires entries in program order: register writeback, store release, and pipeline flush on a mispredicted branch.
- Ids start at 1; id 0 means "no producer".

---
 rtl/rob_core.sv | 133 +++++++++++++
 tb/tb_rob_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_core.sv
// rob_core: in-order retirement buffer with two-CDB capture and operand queries; ROB_PERF_EN adds commit/flush counters
module rob_core #(
    parameter int ROBBW = 4,
    parameter int REGBW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_flag,
    input  logic [REGBW-1:0] issue_rd,
    input  logic             issue_is_store,
    input  logic             issue_is_br,
    output logic [ROBBW-1:0] alloc_id,
    output logic             rob_full,
    input  logic [ROBBW-1:0] id1,
    input  logic [ROBBW-1:0] id2,
    output logic             id1_ready,
    output logic             id2_ready,
    output logic [31:0]      id1_val,
    output logic [31:0]      id2_val,
    input  logic             ex_cdb_flag,
    input  logic [ROBBW-1:0] ex_cdb_rob_id,
    input  logic [31:0]      ex_cdb_val,
    input  logic             ex_cdb_mispred,
    input  logic [31:0]      ex_cdb_pc,
    input  logic             ld_cdb_flag,
    input  logic [ROBBW-1:0] ld_cdb_rob_id,
    input  logic [31:0]      ld_cdb_val,
    output logic             commit_flag,
    output logic [REGBW-1:0] commit_rd,
    output logic [ROBBW-1:0] commit_id,
    output logic [31:0]      commit_val,
    output logic             commit_store,
    output logic             flush,
`ifdef ROB_PERF_EN
    output logic [31:0]      perf_commit_cnt,
    output logic [31:0]      perf_flush_cnt,
`endif
    output logic [31:0]      flush_pc
);
    localparam logic [ROBBW-1:0] DEPTH = '1;
    localparam int N = 2 ** ROBBW;
    logic             valid_q [N];
    logic             ready_q [N];
    logic             st_q    [N];
    logic             br_q    [N];
    logic             mp_q    [N];
    logic [REGBW-1:0] rd_q    [N];
    logic [31:0]      val_q   [N];
    logic [31:0]      pc_q    [N];
    logic [ROBBW-1:0] head, tail, count;
    logic             do_commit, do_issue;

    function automatic logic [ROBBW-1:0] nxt(input logic [ROBBW-1:0] p);
        return (p == DEPTH) ? ROBBW'(1) : p + ROBBW'(1);
    endfunction

    assign alloc_id = tail;
    assign rob_full = count == DEPTH;

    // operand-readiness queries read registered slot state; id 0 is never valid
    always_comb begin
        id1_ready = id1 != '0 && valid_q[id1] && ready_q[id1];
        id2_ready = id2 != '0 && valid_q[id2] && ready_q[id2];
        id1_val   = id1_ready ? val_q[id1] : '0;
        id2_val   = id2_ready ? val_q[id2] : '0;
    end

    // head retirement and dispatch acceptance
    always_comb begin
        do_commit    = rdy && count != '0 && valid_q[head] && ready_q[head];
        commit_flag  = do_commit && rd_q[head] != '0;
        commit_rd    = do_commit ? rd_q[head] : '0;
        commit_id    = do_commit ? head : '0;
        commit_val   = do_commit ? val_q[head] : '0;
        commit_store = do_commit && st_q[head];
        flush        = do_commit && br_q[head] && mp_q[head];
        flush_pc     = flush ? pc_q[head] : '0;
        do_issue     = rdy && issue_flag && !rob_full && !flush;
    end

    // slot state, pointers and occupancy; a flush wipes everything speculative
    always_ff @(posedge clk) begin
        if (rst || (rdy && flush)) begin
            head  <= ROBBW'(1);
            tail  <= ROBBW'(1);
            count <= '0;
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (do_issue) begin
                valid_q[tail] <= 1'b1;
                ready_q[tail] <= 1'b0;
                rd_q[tail]    <= issue_rd;
                st_q[tail]    <= issue_is_store;
                br_q[tail]    <= issue_is_br;
                mp_q[tail]    <= 1'b0;
                tail          <= nxt(tail);
            end
            if (ex_cdb_flag && valid_q[ex_cdb_rob_id]) begin
                ready_q[ex_cdb_rob_id] <= 1'b1;
                val_q[ex_cdb_rob_id]   <= ex_cdb_val;
                mp_q[ex_cdb_rob_id]    <= ex_cdb_mispred;
                pc_q[ex_cdb_rob_id]    <= ex_cdb_pc;
            end
            if (ld_cdb_flag && valid_q[ld_cdb_rob_id]) begin
                ready_q[ld_cdb_rob_id] <= 1'b1;
                val_q[ld_cdb_rob_id]   <= ld_cdb_val;
            end
            if (do_commit) begin
                valid_q[head] <= 1'b0;
                ready_q[head] <= 1'b0;
                head          <= nxt(head);
            end
            count <= count + ROBBW'(do_issue) - ROBBW'(do_commit);
        end
    end

`ifdef ROB_PERF_EN
    // retirement and flush event counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commit_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else if (rdy) begin
            perf_commit_cnt <= perf_commit_cnt + 32'(do_commit);
            perf_flush_cnt  <= perf_flush_cnt + 32'(flush);
        end
    end
`endif
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: directed plus randomized checks of rob_core against a program-order queue model
module tb_rob_core;
    logic        clk = 0, rst = 1, rdy = 0;
    logic        issue_flag = 0, issue_is_store = 0, issue_is_br = 0;
    logic [4:0]  issue_rd = 0;
    logic [3:0]  alloc_id, id1 = 0, id2 = 0, ex_cdb_rob_id = 0, ld_cdb_rob_id = 0, commit_id;
    logic        rob_full, id1_ready, id2_ready;
    logic [31:0] id1_val, id2_val, ex_cdb_val = 0, ex_cdb_pc = 0, ld_cdb_val = 0, commit_val, flush_pc;
    logic        ex_cdb_flag = 0, ex_cdb_mispred = 0, ld_cdb_flag = 0;
    logic        commit_flag, commit_store, flush;
    logic [4:0]  commit_rd;
`ifdef ROB_PERF_EN
    logic [31:0] perf_commit_cnt, perf_flush_cnt;
    int unsigned m_pc, m_pf;
`endif

    rob_core dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_flag(issue_flag), .issue_rd(issue_rd), .issue_is_store(issue_is_store), .issue_is_br(issue_is_br),
        .alloc_id(alloc_id), .rob_full(rob_full),
        .id1(id1), .id2(id2), .id1_ready(id1_ready), .id2_ready(id2_ready), .id1_val(id1_val), .id2_val(id2_val),
        .ex_cdb_flag(ex_cdb_flag), .ex_cdb_rob_id(ex_cdb_rob_id), .ex_cdb_val(ex_cdb_val),
        .ex_cdb_mispred(ex_cdb_mispred), .ex_cdb_pc(ex_cdb_pc),
        .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id), .ld_cdb_val(ld_cdb_val),
        .commit_flag(commit_flag), .commit_rd(commit_rd), .commit_id(commit_id), .commit_val(commit_val),
        .commit_store(commit_store), .flush(flush),
`ifdef ROB_PERF_EN
        .perf_commit_cnt(perf_commit_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          rd;
        bit          st, br, done, mp;
        logic [31:0] val, pc;
    } ent_t;

    ent_t q[$];
    int   m_tail = 1;
    int   passed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void look(input int id, output logic r, output logic [31:0] v);
        r = 0;
        v = 0;
        foreach (q[i]) if (q[i].id == id && q[i].done) begin r = 1; v = q[i].val; end
    endfunction

    task automatic idle();
        rdy = 1; issue_flag = 0; issue_rd = 0; issue_is_store = 0; issue_is_br = 0;
        ex_cdb_flag = 0; ex_cdb_mispred = 0; ld_cdb_flag = 0;
    endtask

    // check every output against the model, clock once, then advance the model
    task automatic cycle();
        ent_t        h;
        logic        ec, ef, acc, r;
        logic [31:0] v;
        #1;
        ec = rdy && q.size() > 0 && q[0].done;
        if (ec) h = q[0];
        ef = ec && h.br && h.mp;
        chk("alloc_id", 32'(alloc_id), 32'(m_tail));
        chk("rob_full", 32'(rob_full), 32'(q.size() == 15));
        chk("commit_flag", 32'(commit_flag), 32'(ec && h.rd != 0));
        chk("commit_store", 32'(commit_store), 32'(ec && h.st));
        chk("flush", 32'(flush), 32'(ef));
        if (ec) begin
            chk("commit_id", 32'(commit_id), 32'(h.id));
            chk("commit_val", commit_val, h.val);
            if (h.rd != 0) chk("commit_rd", 32'(commit_rd), 32'(h.rd));
        end
        if (ef) chk("flush_pc", flush_pc, h.pc);
        look(int'(id1), r, v);
        chk("id1_ready", 32'(id1_ready), 32'(r));
        chk("id1_val", id1_val, v);
        look(int'(id2), r, v);
        chk("id2_ready", 32'(id2_ready), 32'(r));
        chk("id2_val", id2_val, v);
`ifdef ROB_PERF_EN
        chk("perf_commit", perf_commit_cnt, m_pc);
        chk("perf_flush", perf_flush_cnt, m_pf);
`endif
        @(posedge clk);
        if (rdy) begin
`ifdef ROB_PERF_EN
            m_pc += 32'(ec);
            m_pf += 32'(ef);
`endif
            if (ef) begin
                q.delete();
                m_tail = 1;
            end else begin
                acc = issue_flag && q.size() < 15;
                if (ex_cdb_flag)
                    foreach (q[i]) if (q[i].id == int'(ex_cdb_rob_id)) begin
                        q[i].done = 1; q[i].val = ex_cdb_val; q[i].mp = ex_cdb_mispred; q[i].pc = ex_cdb_pc;
                    end
                if (ld_cdb_flag)
                    foreach (q[i]) if (q[i].id == int'(ld_cdb_rob_id)) begin
                        q[i].done = 1; q[i].val = ld_cdb_val;
                    end
                if (ec) void'(q.pop_front());
                if (acc) begin
                    q.push_back('{m_tail, int'(issue_rd), issue_is_store, issue_is_br, 1'b0, 1'b0, 32'h0, 32'h0});
                    m_tail = (m_tail == 15) ? 1 : m_tail + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        q.delete();
        m_tail = 1;
`ifdef ROB_PERF_EN
        m_pc = 0;
        m_pf = 0;
`endif
    endtask

    task automatic iss(input int rd, input bit st, input bit br);
        idle();
        issue_flag = 1; issue_rd = 5'(rd); issue_is_store = st; issue_is_br = br;
        cycle();
    endtask

    task automatic ex(input int id, input logic [31:0] val, input bit mp, input logic [31:0] pc);
        idle();
        ex_cdb_flag = 1; ex_cdb_rob_id = 4'(id); ex_cdb_val = val; ex_cdb_mispred = mp; ex_cdb_pc = pc;
        cycle();
    endtask

    initial begin
        int pick;
        // reset state
        do_reset();
        #1;
        chk("rst_alloc_id", 32'(alloc_id), 1);
        chk("rst_full", 32'(rob_full), 0);
        chk("rst_commit", 32'({commit_flag, commit_store, flush}), 0);
        chk("rst_flush_pc", flush_pc, 0);
        cycle();

        // single issue, capture, commit
        do_reset();
        iss(5, 0, 0);
        ex(1, 32'h1234, 0, 0);
        idle();
        #1;
        chk("t1_flag", 32'(commit_flag), 1);
        chk("t1_rd", 32'(commit_rd), 5);
        chk("t1_id", 32'(commit_id), 1);
        chk("t1_val", commit_val, 32'h1234);
        cycle();
        #1;
        chk("t1_empty_full", 32'(rob_full), 0);
        cycle();

        // fill, wrap, drop when full, reuse of id 1
        do_reset();
        for (int i = 1; i <= 15; i++) iss(i, 0, 0);
        #1;
        chk("t2_full", 32'(rob_full), 1);
        chk("t2_wrap", 32'(alloc_id), 1);
        iss(9, 0, 0);
        #1;
        chk("t2_drop", 32'(alloc_id), 1);
        ex(1, 32'hAA, 0, 0);
        iss(7, 0, 0);
        #1;
        chk("t2_still_full_id", 32'(alloc_id), 1);
        iss(7, 0, 0);
        #1;
        chk("t2_reuse", 32'(alloc_id), 2);
        chk("t2_full_again", 32'(rob_full), 1);
        cycle();

        // out-of-order completion, in-order retirement
        do_reset();
        iss(3, 0, 0);
        iss(4, 1, 0);
        ex(2, 32'hB, 0, 0);
        idle();
        #1;
        chk("t3_wait", 32'(commit_flag), 0);
        cycle();
        ex(1, 32'hA, 0, 0);
        idle();
        #1;
        chk("t3_a_id", 32'(commit_id), 1);
        cycle();
        #1;
        chk("t3_b_id", 32'(commit_id), 2);
        chk("t3_b_store", 32'(commit_store), 1);
        cycle();

        // mispredicted branch at head flushes younger entries
        do_reset();
        iss(1, 0, 1);
        for (int i = 0; i < 3; i++) iss(6 + i, 0, 0);
        ex(1, 32'h44, 1, 32'h80);
        idle();
        issue_flag = 1; issue_rd = 2;
        #1;
        chk("t4_commit", 32'(commit_flag), 1);
        chk("t4_flush", 32'(flush), 1);
        chk("t4_pc", flush_pc, 32'h80);
        cycle();
        idle();
        #1;
        chk("t4_alloc", 32'(alloc_id), 1);
        for (int i = 1; i <= 4; i++) begin
            id1 = 4'(i);
            #1;
            chk("t4_q_ready", 32'(id1_ready), 0);
        end
        cycle();

        // dual CDB capture then rdy-low hold
        do_reset();
        for (int i = 0; i < 3; i++) iss(10 + i, 0, 0);
        idle();
        ex_cdb_flag = 1; ex_cdb_rob_id = 2; ex_cdb_val = 32'h22;
        ld_cdb_flag = 1; ld_cdb_rob_id = 3; ld_cdb_val = 32'h33;
        cycle();
        idle();
        id1 = 2; id2 = 3;
        #1;
        chk("t5_r1", 32'(id1_ready), 1);
        chk("t5_v1", id1_val, 32'h22);
        chk("t5_r2", 32'(id2_ready), 1);
        chk("t5_v2", id2_val, 32'h33);
        cycle();
        ex(1, 32'h11, 0, 0);
        for (int i = 0; i < 3; i++) begin
            rdy = 0; issue_flag = 1;
            #1;
            chk("t5_hold_commit", 32'(commit_flag), 0);
            cycle();
        end
        idle();
        #1;
        chk("t5_hold_alloc", 32'(alloc_id), 4);
        chk("t5_after_commit", 32'(commit_id), 1);
        cycle();

        // randomized traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy = ($urandom_range(7) != 0);
            issue_flag = ($urandom_range(9) < 6);
            issue_rd = 5'($urandom);
            issue_is_store = ($urandom_range(3) == 0);
            issue_is_br = ($urandom_range(4) == 0);
            id1 = 4'($urandom);
            id2 = 4'($urandom);
            if ($urandom_range(1) == 1) begin
                ex_cdb_flag = 1;
                pick = (q.size() > 0 && $urandom_range(4) != 0) ? q[$urandom_range(q.size() - 1)].id : int'($urandom_range(15, 1));
                ex_cdb_rob_id = 4'(pick);
                ex_cdb_val = $urandom;
                ex_cdb_pc = $urandom;
                ex_cdb_mispred = ($urandom_range(5) == 0);
            end
            if ($urandom_range(2) == 0) begin
                pick = (q.size() > 0) ? q[$urandom_range(q.size() - 1)].id : int'($urandom_range(15, 1));
                if (!(ex_cdb_flag && 4'(pick) == ex_cdb_rob_id)) begin
                    ld_cdb_flag = 1;
                    ld_cdb_rob_id = 4'(pick);
                    ld_cdb_val = $urandom;
                end
            end
            cycle();
        end

`ifdef ROB_PERF_EN
        do_reset();
        #1;
        chk("perf_rst_commit", perf_commit_cnt, 0);
        chk("perf_rst_flush", perf_flush_cnt, 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
